// File: rtl/vend_coin_arbiter.sv
// ---------------------------------------------------------------------------
// vend_coin_arbiter
//
// Purpose:
//   Two coin slots feed one drink machine. Each slot has a small coin FIFO.
//   A round-robin arbiter grants a session to one slot, which then owns the
//   machine until a vend happens or the session goes idle for too long.
//   Owner coins are forwarded as registered one-cycle pulses. A shadow credit
//   counter (in nickels) predicts when the machine vends and what change it
//   owes.
//
// Parameters:
//   FIFO_DEPTH       entries per slot FIFO (power of 2, >= 2)
//   SESSION_TIMEOUT  idle owner cycles before the session is abandoned (1..255)
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   req0_valid/req0_coin/ready   slot 0 coin handshake (01 N, 10 D, 11 Q, 00 bad)
//   req1_valid/req1_coin/ready   slot 1 coin handshake
//   nickel_in/dime_in/quarter_in registered coin pulses to the machine
//   dispense                     machine dispense (prediction check only)
//   owner_valid/owner_id         current session owner
//   vend_done/change_nickels     vend pulse and change due in nickels
//   abandon                      session timeout pulse
//   pred_error                   sticky prediction mismatch flag
//
// Configuration macro:
//   VEND_COIN_ARBITER_PRED_CHECK_EN  enables the dispense-vs-prediction check;
//                                    when undefined pred_error is tied low.
// ---------------------------------------------------------------------------
module vend_coin_arbiter #(
    parameter int FIFO_DEPTH      = 2,
    parameter int SESSION_TIMEOUT = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [1:0] req0_coin,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_coin,
    output logic       req1_ready,
    output logic       nickel_in,
    output logic       dime_in,
    output logic       quarter_in,
    input  logic       dispense,
    output logic       owner_valid,
    output logic       owner_id,
    output logic       vend_done,
    output logic [2:0] change_nickels,
    output logic       abandon,
    output logic       pred_error
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] TMO_LAST = 8'(SESSION_TIMEOUT - 1);

    typedef enum logic {ACCUM = 1'b0, VEND = 1'b1} state_t;

    // Slot FIFO storage and bookkeeping
    logic [1:0]    mem_q [2][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q [2], wr_ptr_d [2];
    logic [PW-1:0] rd_ptr_q [2], rd_ptr_d [2];
    logic [CW-1:0] count_q [2], count_d [2];
    logic [1:0]    coin_in [2];
    logic [1:0]    head [2];
    logic [1:0]    in_valid, full, empty, push, pop;

    // Session / arbitration state
    state_t     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic       owner_valid_q, owner_valid_d;
    logic       owner_id_q, owner_id_d;
    logic       rr_q, rr_d;
    logic [7:0] tmo_q, tmo_d;
    logic [2:0] pulse_q, pulse_d;
    logic       vend_done_q, vend_done_d;
    logic [2:0] change_q, change_d;
    logic       abandon_q, abandon_d;
    logic       pred_error_q, pred_error_d;

    logic       sel, take;
    logic [1:0] head_sel;
    logic [3:0] credit_sum;

    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            2'b01:   return 4'd1;
            2'b10:   return 4'd2;
            2'b11:   return 4'd5;
            default: return 4'd0;
        endcase
    endfunction

    assign in_valid   = {req1_valid, req0_valid};
    assign coin_in[0] = req0_coin;
    assign coin_in[1] = req1_coin;

    // FIFO status and pointer updates; ready only looks at fullness so a
    // full FIFO stays not-ready even in a cycle where it also pops.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            full[s]     = (count_q[s] == CW'(FIFO_DEPTH));
            empty[s]    = (count_q[s] == '0);
            head[s]     = mem_q[s][rd_ptr_q[s]];
            push[s]     = in_valid[s] & ~full[s];
            wr_ptr_d[s] = wr_ptr_q[s] + PW'(push[s]);
            rd_ptr_d[s] = rd_ptr_q[s] + PW'(pop[s]);
            count_d[s]  = count_q[s] + CW'(push[s]) - CW'(pop[s]);
        end
    end

    assign req0_ready = ~full[0];
    assign req1_ready = ~full[1];

    // Coin storage carries no reset: only the pointers and counts define
    // which entries are live.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s]] <= coin_in[s];
            end
        end
    end

    // Arbitration, credit tracking, vend and timeout. An illegal code is
    // popped and dropped without touching ownership, credit or the timer.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        owner_valid_d = owner_valid_q;
        owner_id_d    = owner_id_q;
        rr_d          = rr_q;
        tmo_d         = tmo_q;
        pulse_d       = 3'b000;
        vend_done_d   = 1'b0;
        change_d      = 3'd0;
        abandon_d     = 1'b0;
        pop           = 2'b00;
        sel           = owner_id_q;
        take          = 1'b0;
        head_sel      = 2'b00;
        credit_sum    = credit_q;

        case (state_q)
            ACCUM: begin
                if (owner_valid_q) begin
                    take = ~empty[owner_id_q];
                end else if (!empty[0] && !empty[1]) begin
                    sel  = rr_q;
                    take = 1'b1;
                end else if (!empty[0]) begin
                    sel  = 1'b0;
                    take = 1'b1;
                end else if (!empty[1]) begin
                    sel  = 1'b1;
                    take = 1'b1;
                end

                head_sel   = head[sel];
                credit_sum = credit_q + coin_value(head_sel);

                if (take) begin
                    pop[sel] = 1'b1;
                    if (head_sel != 2'b00) begin
                        owner_valid_d = 1'b1;
                        owner_id_d    = sel;
                        tmo_d         = 8'd0;
                        credit_d      = credit_sum;
                        pulse_d       = {head_sel == 2'b01, head_sel == 2'b10, head_sel == 2'b11};
                        if (credit_sum >= 4'd10) begin
                            state_d = VEND;
                        end
                    end
                end else if (owner_valid_q) begin
                    // Idle owner: release it but keep the credit for the
                    // next grantee.
                    if (tmo_q == TMO_LAST) begin
                        abandon_d     = 1'b1;
                        owner_valid_d = 1'b0;
                        rr_d          = ~owner_id_q;
                        tmo_d         = 8'd0;
                    end else begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end
            end

            VEND: begin
                vend_done_d   = 1'b1;
                change_d      = 3'(credit_q - 4'd10);
                credit_d      = 4'd0;
                owner_valid_d = 1'b0;
                rr_d          = ~owner_id_q;
                tmo_d         = 8'd0;
                state_d       = ACCUM;
            end

            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // The prediction is the registered vend pulse, i.e. the cycle in which
    // the machine itself is expected to dispense.
`ifdef VEND_COIN_ARBITER_PRED_CHECK_EN
    always_comb begin
        pred_error_d = pred_error_q | (dispense != vend_done_q);
    end
`else
    logic unused_dispense;
    assign unused_dispense = dispense;

    always_comb begin
        pred_error_d = 1'b0;
    end
`endif

    // State register: everything except coin storage is cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ACCUM;
            credit_q      <= 4'd0;
            owner_valid_q <= 1'b0;
            owner_id_q    <= 1'b0;
            rr_q          <= 1'b0;
            tmo_q         <= 8'd0;
            pulse_q       <= 3'b000;
            vend_done_q   <= 1'b0;
            change_q      <= 3'd0;
            abandon_q     <= 1'b0;
            pred_error_q  <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            owner_valid_q <= owner_valid_d;
            owner_id_q    <= owner_id_d;
            rr_q          <= rr_d;
            tmo_q         <= tmo_d;
            pulse_q       <= pulse_d;
            vend_done_q   <= vend_done_d;
            change_q      <= change_d;
            abandon_q     <= abandon_d;
            pred_error_q  <= pred_error_d;
            for (int s = 0; s < 2; s++) begin
                wr_ptr_q[s] <= wr_ptr_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                count_q[s]  <= count_d[s];
            end
        end
    end

    assign nickel_in      = pulse_q[2];
    assign dime_in        = pulse_q[1];
    assign quarter_in     = pulse_q[0];
    assign owner_valid    = owner_valid_q;
    assign owner_id       = owner_id_q;
    assign vend_done      = vend_done_q;
    assign change_nickels = change_q;
    assign abandon        = abandon_q;
    assign pred_error     = pred_error_q;

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vend_coin_arbiter
//
// Purpose: self-checking bench for vend_coin_arbiter. Expected output
// records are queued with the cycle they are due in when stimulus is driven,
// and compared as the bench reaches that cycle. A small table covers single
// coins; hand-written sequences cover vend, arbitration, timeout and reset.
// ---------------------------------------------------------------------------
module tb_vend_coin_arbiter;

    localparam int DEPTH = 2;
    localparam int TMO   = 4;

    localparam logic [2:0] PN = 3'b100;
    localparam logic [2:0] PD = 3'b010;
    localparam logic [2:0] PQ = 3'b001;
    localparam logic [2:0] P0 = 3'b000;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_coin, req1_coin;
    logic       req0_ready, req1_ready;
    logic       nickel_in, dime_in, quarter_in;
    logic       dispense;
    logic       owner_valid, owner_id;
    logic       vend_done;
    logic [2:0] change_nickels;
    logic       abandon, pred_error;

    typedef struct {
        int         due;
        string      name;
        logic [2:0] pulse;
        logic       vd;
        logic [2:0] chg;
        logic       ab;
        logic       chk_own;
        logic       ov;
        logic       oid;
    } exp_t;

    typedef struct {
        logic [1:0] code;
        logic [2:0] pulse;
        logic       owned;
    } vec_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    vend_coin_arbiter #(.FIFO_DEPTH(DEPTH), .SESSION_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_coin(req0_coin), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_coin(req1_coin), .req1_ready(req1_ready),
        .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
        .dispense(dispense), .owner_valid(owner_valid), .owner_id(owner_id),
        .vend_done(vend_done), .change_nickels(change_nickels),
        .abandon(abandon), .pred_error(pred_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic checkOutput(input exp_t e);
        compare(e.name, 16'({nickel_in, dime_in, quarter_in, vend_done, change_nickels, abandon}),
                16'({e.pulse, e.vd, e.chg, e.ab}));
        if (e.chk_own)
            compare({e.name, " owner"}, 16'({owner_valid, owner_id}), 16'({e.ov, e.oid}));
    endtask

    // Queue an expectation, kept sorted by due cycle.
    task automatic expectAt(input int due, input string name, input logic [2:0] pulse,
                            input logic vd, input logic [2:0] chg, input logic ab,
                            input logic chk_own, input logic ov, input logic oid);
        exp_t e;
        int   pos;
        e.due = due; e.name = name; e.pulse = pulse; e.vd = vd; e.chg = chg;
        e.ab = ab; e.chk_own = chk_own; e.ov = ov; e.oid = oid;
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > due) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checkOutput(e);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [1:0] c0,
                                 input logic v1, input logic [1:0] c1);
        req0_valid = v0; req0_coin = c0;
        req1_valid = v1; req1_coin = c1;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        dispense = 1'b0;
        applyStimulus(0, 2'b00, 0, 2'b00);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vec_t vt[4];
        int   r;
        logic exp_pred;

        vt[0] = '{2'b01, PN, 1'b1};
        vt[1] = '{2'b10, PD, 1'b1};
        vt[2] = '{2'b11, PQ, 1'b1};
        vt[3] = '{2'b00, P0, 1'b0};

        // Reset state
        doReset();
        compare("reset outputs",
                16'({nickel_in, dime_in, quarter_in, vend_done, change_nickels, abandon,
                     owner_valid, owner_id, pred_error}), 16'h0);
        compare("reset readys", 16'({req0_ready, req1_ready}), 16'h3);

        // Single-coin table: pulse one cycle after the pop, then idle
        for (int i = 0; i < 4; i++) begin
            doReset();
            applyStimulus(1, vt[i].code, 0, 2'b00);
            expectAt(cyc + 2, $sformatf("vec%0d pulse", i), vt[i].pulse, 0, 3'd0, 0, 1, vt[i].owned, 0);
            expectAt(cyc + 3, $sformatf("vec%0d idle", i), P0, 0, 3'd0, 0, 0, 0, 0);
            tick();
            applyStimulus(0, 2'b00, 0, 2'b00);
            repeat (3) tick();
        end

        // Two quarters -> vend with no change, no pulse in the vend cycle
        doReset();
        r = cyc;
        expectAt(r + 2, "qq first", PQ, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 3, "qq second", PQ, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 4, "qq vend", P0, 1, 3'd0, 0, 1, 0, 0);
        expectAt(r + 5, "qq after", P0, 0, 3'd0, 0, 0, 0, 0);
        applyStimulus(1, 2'b11, 0, 2'b00);
        tick();
        tick();
        applyStimulus(0, 2'b00, 0, 2'b00);
        repeat (4) tick();

        // Both slots offer dimes: slot0 wins, slot1 waits, then timeout
        doReset();
        r = cyc;
        for (int i = 0; i < 5; i++)
            expectAt(r + 2 + i, $sformatf("arb dime0 %0d", i), PD, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 7, "arb vend", P0, 1, 3'd0, 0, 1, 0, 0);
        expectAt(r + 8, "arb slot1 grant", PD, 0, 3'd0, 0, 1, 1, 1);
        expectAt(r + 9, "arb slot1 dime2", PD, 0, 3'd0, 0, 1, 1, 1);
        expectAt(r + 12, "arb pre-abandon", P0, 0, 3'd0, 0, 1, 1, 1);
        expectAt(r + 13, "arb abandon", P0, 0, 3'd0, 1, 1, 0, 1);
        applyStimulus(1, 2'b10, 1, 2'b10);
        repeat (4) tick();
        compare("slot1 full ready", 16'(req1_ready), 16'h0);
        compare("slot0 ready", 16'(req0_ready), 16'h1);
        tick();
        applyStimulus(0, 2'b00, 1, 2'b10);
        tick();
        applyStimulus(0, 2'b00, 0, 2'b00);
        repeat (8) tick();
        compare("slot1 drained ready", 16'(req1_ready), 16'h1);

        // Nine nickels then a quarter -> change of four nickels
        doReset();
        r = cyc;
        for (int i = 0; i < 9; i++)
            expectAt(r + 2 + i, $sformatf("nickel %0d", i), PN, 0, 3'd0, 0, 0, 0, 0);
        expectAt(r + 11, "nickels quarter", PQ, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 12, "nickels vend", P0, 1, 3'd4, 0, 1, 0, 0);
        expectAt(r + 13, "nickels after", P0, 0, 3'd0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 2'b01, 0, 2'b00);
            tick();
        end
        applyStimulus(1, 2'b11, 0, 2'b00);
        tick();
        applyStimulus(0, 2'b00, 0, 2'b00);
        repeat (4) tick();

        // Timeout keeps credit: dime(2) abandoned, slot1 Q+D+N reaches 10
        doReset();
        r = cyc;
        expectAt(r + 2, "tmo dime", PD, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 5, "tmo pre-abandon", P0, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 6, "tmo abandon", P0, 0, 3'd0, 1, 1, 0, 0);
        expectAt(r + 8, "tmo slot1 quarter", PQ, 0, 3'd0, 0, 1, 1, 1);
        expectAt(r + 9, "tmo slot1 dime", PD, 0, 3'd0, 0, 1, 1, 1);
        expectAt(r + 10, "tmo slot1 nickel", PN, 0, 3'd0, 0, 1, 1, 1);
        expectAt(r + 11, "tmo inherited vend", P0, 1, 3'd0, 0, 1, 0, 1);
        applyStimulus(1, 2'b10, 0, 2'b00);
        tick();
        applyStimulus(0, 2'b00, 0, 2'b00);
        repeat (5) tick();
        applyStimulus(0, 2'b00, 1, 2'b11);
        tick();
        applyStimulus(0, 2'b00, 1, 2'b10);
        tick();
        applyStimulus(0, 2'b00, 1, 2'b01);
        tick();
        applyStimulus(0, 2'b00, 0, 2'b00);
        repeat (3) tick();

        // Reset mid-session with credit 6 and two queued slot1 coins
        doReset();
        r = cyc;
        expectAt(r + 2, "mid quarter", PQ, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 3, "mid nickel", PN, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 4, "mid reset outputs", P0, 0, 3'd0, 0, 1, 0, 0);
        for (int i = 5; i <= 8; i++)
            expectAt(r + i, $sformatf("post reset idle %0d", i), P0, 0, 3'd0, 0, 1, 0, 0);
        expectAt(r + 9, "post reset q1", PQ, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 10, "post reset q2", PQ, 0, 3'd0, 0, 1, 1, 0);
        expectAt(r + 11, "post reset vend", P0, 1, 3'd0, 0, 1, 0, 0);
        applyStimulus(1, 2'b11, 1, 2'b10);
        tick();
        applyStimulus(1, 2'b01, 1, 2'b10);
        tick();
        applyStimulus(0, 2'b00, 0, 2'b00);
        tick();
        reset = 1'b1;
        tick();
        compare("mid reset readys", 16'({req0_ready, req1_ready}), 16'h3);
        compare("mid reset pred_error", 16'(pred_error), 16'h0);
        reset = 1'b0;
        repeat (3) tick();
        applyStimulus(1, 2'b11, 0, 2'b00);
        tick();
        tick();
        applyStimulus(0, 2'b00, 0, 2'b00);
        repeat (4) tick();

        // Prediction check: dispense in an accumulate cycle
`ifdef VEND_COIN_ARBITER_PRED_CHECK_EN
        exp_pred = 1'b1;
`else
        exp_pred = 1'b0;
`endif
        doReset();
        compare("pred clear", 16'(pred_error), 16'h0);
        dispense = 1'b1;
        tick();
        dispense = 1'b0;
        compare("pred set", 16'(pred_error), 16'(exp_pred));
        repeat (3) tick();
        compare("pred sticky", 16'(pred_error), 16'(exp_pred));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        compare("pred reset", 16'(pred_error), 16'h0);

        repeat (2) tick();
        compare("scoreboard drained", 16'(sb.size()), 16'h0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vend_coin_arbiter.md
VEND_COIN_ARBITER -- requirements
Module: vend_coin_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, entries per requester coin FIFO (power of 2, minimum 2).
REQ-002 Parameter: SESSION_TIMEOUT, default 200, idle cycles before the session owner is released (range 1..255).
REQ-003 Port: clk  input  1  the single clock; all logic on posedge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req0_valid, req1_valid  input  1 each  coin offered by coin slot 0 / slot 1.
REQ-006 Port: req0_coin, req1_coin  input  2 each  coin code: 01 nickel, 10 dime, 11 quarter, 00 illegal.
REQ-007 Port: req0_ready, req1_ready  output  1 each  slot FIFO can accept a coin.
REQ-008 Port: nickel_in, dime_in, quarter_in  output  1 each  registered one-cycle coin pulses to the drink machine; at most one high per cycle.
REQ-009 Port: dispense  input  1  dispense output of the drink machine; used only under the configuration macro.
REQ-010 Port: owner_valid  output  1  a session owner exists.
REQ-011 Port: owner_id  output  1  current session owner slot.
REQ-012 Port: vend_done  output  1  one-cycle pulse in the machine's vend cycle.
REQ-013 Port: change_nickels  output  3  change due in nickels (0..4), valid with vend_done.
REQ-014 Port: abandon  output  1  one-cycle pulse when a session times out.
REQ-015 Port: pred_error  output  1  sticky vend-prediction mismatch flag.

Function
REQ-016 Handshake: a coin transfers on clk when reqN_valid and reqN_ready are both high; reqN_ready = FIFO not full, even when that FIFO pops in the same cycle.
REQ-017 A popped code of 00 is discarded: no pulse, no credit change, no timeout-counter reset.
REQ-018 Shadow credit: 4-bit count in nickels; nickel adds 1, dime adds 2, quarter adds 5.
REQ-019 FSM states: ACCUM and VEND.
REQ-020 In ACCUM with no owner: round-robin grant among non-empty FIFOs; the slot after the last owner wins a tie; the winner becomes owner and its head coin issues that cycle.
REQ-021 In ACCUM with an owner: only the owner FIFO pops, one coin per cycle; the other slot's coins are held.
REQ-022 Latency: a coin popped in cycle t drives its pulse in cycle t+1.
REQ-023 If the post-add credit is 10 or more: go to VEND.
REQ-024 VEND lasts exactly one cycle and issues no coin.
REQ-025 In VEND: vend_done=1 and change_nickels = credit-10.
REQ-026 Leaving VEND: credit cleared, owner released, round-robin pointer updated, return to ACCUM.
REQ-027 Timeout counter: cleared on each owner issue; increments in ACCUM while owner_valid and the owner FIFO is empty.
REQ-028 On reaching SESSION_TIMEOUT: pulse abandon, release owner, keep credit, clear counter.
REQ-029 After a timeout, the next grantee inherits the retained credit.
REQ-030 A push and a pop on the same FIFO in the same cycle are both honoured.

Reset
REQ-031 reset clears: FIFOs, credit, timeout counter, pred_error, all pulses, owner_valid, owner_id=0.
REQ-032 After reset: FSM=ACCUM; round-robin favours slot 0.
REQ-033 reset mid-session discards all queued coins; no vend_done or abandon is produced.

Configuration
REQ-034 VEND_COIN_ARBITER_PRED_CHECK_EN defined: compare the registered prediction "in VEND" with dispense each cycle; set pred_error on any mismatch; pred_error holds until reset.
REQ-035 VEND_COIN_ARBITER_PRED_CHECK_EN undefined: pred_error tied 0 and dispense ignored.

Verification
REQ-036 Slot0 pushes quarter, quarter -> quarter_in high in two consecutive cycles, then vend_done=1 with change_nickels=0, owner_id=0, no pulse in that cycle.
REQ-037 After reset, both slots push a dime in the same cycle -> slot0 owns and issues 5 dimes; slot1 stays queued with ready=0 once full; slot1 is granted in the cycle after vend.
REQ-038 Slot0 issues 9 nickels, then a quarter -> vend_done with change_nickels=4.
REQ-039 Slot0 pushes one dime then goes idle; SESSION_TIMEOUT=4 -> abandon 4 cycles after the issue; slot1 quarter then owns with credit 7.
REQ-040 Under PRED_CHECK_EN, force dispense=1 in an ACCUM cycle -> pred_error=1 and stays set until reset.
REQ-041 Assert reset with credit 6 and 2 queued coins -> all outputs 0 next cycle, credit 0, readys high.
